// File: rtl/clocked_signal.sv
// Free-running raster timing generator: sync, data enable, coordinates, line/frame
// strobes and a completed-frame counter, all registered on the rising clock edge.
module clocked_signal #(
  parameter int H_ACTIVE = 16,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 12,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 1,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int FC_W     = 16,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W     = $clog2(H_TOTAL),
  localparam int Y_W     = $clog2(V_TOTAL)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            hs,
  output logic            vs,
  output logic            de,
  output logic [X_W-1:0]  x,
  output logic [Y_W-1:0]  y,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_cnt
);

  localparam int HS_BEGIN = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEGIN = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [X_W-1:0] h, h_nxt;
  logic [Y_W-1:0] v, v_nxt;
  logic           h_last, v_last, wrap;
  logic           started;
  logic           de_nxt, hs_act_nxt, vs_act_nxt;

  // Comparisons are done at int width so a window end equal to a power of two
  // cannot alias to zero in the narrow counter width.
  assign h_last = (int'(h) == H_TOTAL - 1);
  assign v_last = (int'(v) == V_TOTAL - 1);
  assign wrap   = h_last && v_last;

  // NOTE: outputs are decoded from the *next* position so that, once registered,
  // they line up with the position register in the same cycle.
  always_comb begin
    h_nxt = h_last ? '0 : h + 1'b1;
    v_nxt = v;
    if (h_last) begin
      v_nxt = v_last ? '0 : v + 1'b1;
    end
    de_nxt     = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
    hs_act_nxt = (int'(h_nxt) >= HS_BEGIN) && (int'(h_nxt) < HS_END);
    vs_act_nxt = (int'(v_nxt) >= VS_BEGIN) && (int'(v_nxt) < VS_END);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h           <= X_W'(H_TOTAL - 1);
      v           <= Y_W'(V_TOTAL - 1);
      started     <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      h           <= h_nxt;
      v           <= v_nxt;
      hs          <= hs_act_nxt ? HS_POL : ~HS_POL;
      vs          <= vs_act_nxt ? VS_POL : ~VS_POL;
      de          <= de_nxt;
      x           <= h_nxt;
      y           <= v_nxt;
      line_start  <= (h_nxt == '0);
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
      // The entry into (0,0) right after reset is not a completed frame.
      if (wrap) begin
        started <= 1'b1;
        if (started) begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clocked_signal.sv
// Self-checking bench for clocked_signal: two instances (active-high and active-low
// sync polarity) compared each cycle against an arithmetic raster model.
module tb_clocked_signal;

  localparam int HT = 24;
  localparam int VT = 16;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        hs_a, vs_a, de_a, ls_a, fs_a;
  logic [4:0]  x_a;
  logic [3:0]  y_a;
  logic [15:0] fc_a;
  logic        hs_b, vs_b, de_b, ls_b, fs_b;
  logic [4:0]  x_b;
  logic [3:0]  y_b;
  logic [15:0] fc_b;

  int unsigned n;          // index of the next post-release edge to be checked
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  clocked_signal u_pos (
    .clk(clk), .rst(rst), .hs(hs_a), .vs(vs_a), .de(de_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  clocked_signal #(.HS_POL(1'b0), .VS_POL(1'b0)) u_neg (
    .clk(clk), .rst(rst), .hs(hs_b), .vs(vs_b), .de(de_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  logic [29:0] act_a, act_b;
  assign act_a = {hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a, fc_a};
  assign act_b = {hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b, fc_b};

  // Expected outputs at the n-th edge after release, from raster arithmetic.
  function automatic logic [29:0] model(int unsigned k, bit pol);
    int unsigned hh, vv, ff;
    logic hs_e, vs_e, de_e;
    hh   = k % HT;
    vv   = (k / HT) % VT;
    ff   = (k / FT) % 65536;
    de_e = (hh < 16) && (vv < 12);
    hs_e = (hh >= 18 && hh <= 21) ? pol : ~pol;
    vs_e = (vv >= 13 && vv <= 14) ? pol : ~pol;
    return {hs_e, vs_e, de_e, 5'(hh), 4'(vv), hh == 0, (hh == 0) && (vv == 0), 16'(ff)};
  endfunction

  function automatic logic [29:0] reset_vec(bit pol);
    return {~pol, ~pol, 28'b0};
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (act_a !== reset_vec(1'b1)) $display("FAIL reset_hold_pos got=%h exp=%h", act_a, reset_vec(1'b1));
    else passed++;
    checks++;
    if (act_b !== reset_vec(1'b0)) $display("FAIL reset_hold_neg got=%h exp=%h", act_b, reset_vec(1'b0));
    else passed++;
  endtask

  task automatic test_release;
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (act_a !== model(n, 1'b1)) $display("FAIL release_pos edge=%0d got=%h exp=%h", n, act_a, model(n, 1'b1));
      else passed++;
      checks++;
      if (act_b !== model(n, 1'b0)) $display("FAIL release_neg edge=%0d got=%h exp=%h", n, act_b, model(n, 1'b0));
      else passed++;
      n++;
    end
  endtask

  // Runs through lines 1 and 2 and counts per-line features.
  task automatic test_line_timing;
    int hs_cnt = 0, de_cnt = 0, ls_cnt = 0;
    while (n < 3 * HT) begin
      @(posedge clk);
      #1;
      checks++;
      if (act_a !== model(n, 1'b1)) $display("FAIL line_pos edge=%0d got=%h exp=%h", n, act_a, model(n, 1'b1));
      else passed++;
      if (n >= HT) begin
        hs_cnt += int'(hs_a);
        de_cnt += int'(de_a);
        ls_cnt += int'(ls_a);
      end
      n++;
    end
    checks++;
    if (hs_cnt != 8) $display("FAIL line_hs_count got=%0d exp=8", hs_cnt); else passed++;
    checks++;
    if (de_cnt != 32) $display("FAIL line_de_count got=%0d exp=32", de_cnt); else passed++;
    checks++;
    if (ls_cnt != 2) $display("FAIL line_start_count got=%0d exp=2", ls_cnt); else passed++;
  endtask

  // Runs through two frame wraps; checks vs pulse shape and frame strobes.
  task automatic test_frame_timing;
    int          fs_cnt = 0, blank_de = 0, vs_run = 0, vs_pulses = 0;
    int unsigned vs_start = 0;
    while (n < 2 * FT + HT) begin
      @(posedge clk);
      #1;
      checks++;
      if ({act_a, act_b} !== {model(n, 1'b1), model(n, 1'b0)})
        $display("FAIL frame edge=%0d got=%h/%h exp=%h/%h", n, act_a, act_b, model(n, 1'b1), model(n, 1'b0));
      else passed++;
      fs_cnt += int'(fs_a);
      if (((n / HT) % VT) >= 12 && de_a) blank_de++;
      if (vs_a) begin
        if (vs_run == 0) vs_start = n;
        vs_run++;
      end else if (vs_run != 0) begin
        vs_pulses++;
        checks++;
        if (vs_run != 48 || (vs_start % FT) != 13 * HT)
          $display("FAIL vs_pulse len=%0d start=%0d exp len=48 start=%0d", vs_run, vs_start % FT, 13 * HT);
        else passed++;
        vs_run = 0;
      end
      n++;
    end
    checks++;
    if (vs_pulses != 2) $display("FAIL vs_pulse_count got=%0d exp=2", vs_pulses); else passed++;
    checks++;
    if (blank_de != 0) $display("FAIL de_in_blanking got=%0d exp=0", blank_de); else passed++;
    checks++;
    if (fs_cnt != 2) $display("FAIL frame_start_count got=%0d exp=2", fs_cnt); else passed++;
    checks++;
    if (fc_a !== 16'd2) $display("FAIL frame_cnt_after_two got=%0d exp=2", fc_a); else passed++;
  endtask

  // Runs to a target raster position, asserts reset between edges, then restarts.
  task automatic mid_reset(int unsigned target, int unsigned hold, string tag);
    int guard = 0;
    while ((n == 0 || ((n - 1) % FT) != target) && guard < 2 * FT) begin
      @(posedge clk);
      #1;
      checks++;
      if (act_a !== model(n, 1'b1)) $display("FAIL %s_run edge=%0d got=%h exp=%h", tag, n, act_a, model(n, 1'b1));
      else passed++;
      n++;
      guard++;
    end
    checks++;
    if (guard >= 2 * FT) $display("FAIL %s_reach got=%0d exp=%0d", tag, (n - 1) % FT, target);
    else passed++;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({act_a, act_b} !== {reset_vec(1'b1), reset_vec(1'b0)})
      $display("FAIL %s_async got=%h/%h exp=%h/%h", tag, act_a, act_b, reset_vec(1'b1), reset_vec(1'b0));
    else passed++;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({act_a, act_b} !== {model(n, 1'b1), model(n, 1'b0)})
        $display("FAIL %s_restart edge=%0d got=%h/%h exp=%h/%h", tag, n, act_a, act_b, model(n, 1'b1), model(n, 1'b0));
      else passed++;
      n++;
    end
  endtask

  task automatic test_mid_frame_reset;
    mid_reset(5 * HT + 7, 1, "mid_reset");
  endtask

  task automatic test_random_resets;
    for (int k = 0; k < 4; k++) begin
      mid_reset($urandom_range(FT - 1, 0), $urandom_range(3, 0), "rand_reset");
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_line_timing();
    test_frame_timing();
    test_mid_frame_reset();
    test_random_resets();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/clocked_signal.md
# clocked_signal

Free-running raster timing generator driven by a single clock. After reset it produces horizontal sync, vertical sync, data enable, pixel coordinates, line/frame start strobes and a frame counter. It is the timing source for the video simulation environment: downstream pixel producers and checkers sample its outputs on the same clock edge.

## Interface
- H_ACTIVE, 16, active pixels per line
- H_FP, 2, horizontal front porch (cycles)
- H_SYNC, 4, horizontal sync width (cycles)
- H_BP, 2, horizontal back porch (cycles)
- V_ACTIVE, 12, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 1, vertical back porch (lines)
- HS_POL, 1, hs asserted level (1 = active-high)
- VS_POL, 1, vs asserted level (1 = active-high)
- FC_W, 16, frame counter width
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (24); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (16); X_W = $clog2(H_TOTAL); Y_W = $clog2(V_TOTAL)

Ports (clk and rst are the first two, in that order):
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- de  out  1  active-video enable
- x  out  X_W  horizontal position 0..H_TOTAL-1
- y  out  Y_W  vertical position 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse at x==0
- frame_start  out  1  one-cycle pulse at x==0, y==0
- frame_cnt  out  FC_W  completed-frame count

## Operation
- Internal position (h,v). While rst==0: h=H_TOTAL-1, v=V_TOTAL-1, all outputs at reset values.
- Each rising edge with rst==1: h increments; at H_TOTAL-1 it wraps to 0 and v increments; v wraps from V_TOTAL-1 to 0.
- First edge after rst release moves to (0,0): frame_start=1, line_start=1, de=1, x=y=0.
- Decode, all outputs registered and consistent with current (h,v) in the same cycle:
  - x=h, y=v
  - de = (h<H_ACTIVE) && (v<V_ACTIVE)
  - hs = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
  - vs = VS_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole lines, changes at h==0), else ~VS_POL
  - line_start = (h==0); frame_start = (h==0 && v==0)
- frame_cnt increments by 1 (modulo 2^FC_W) on every wrap from (H_TOTAL-1,V_TOTAL-1) to (0,0) except the first entry after reset; so it is 0 during the first frame.
- Reset values: hs=~HS_POL, vs=~VS_POL, de=0, line_start=0, frame_start=0, x=0, y=0, frame_cnt=0.
- Any porch parameter may be 0; sync widths are at least 1.

## Timing
- Latency from rst release: first rising edge following deassertion shows (0,0).
- Assertion of rst mid-frame clears outputs immediately (asynchronous), no waiting for a clock edge. The next release restarts at (0,0) with frame_cnt=0.
- Period: line = H_TOTAL cycles (24), frame = H_TOTAL*V_TOTAL cycles (384).
- Defaults: de high for h 0..15 on lines 0..11; hs high for h 18..21; vs high for lines 13..14 (cycles v*24 .. v*24+23).
- Wrap events coincide on one edge: h, v and frame_cnt all update together at the (23,15) to (0,0) transition.

## Test plan
- Reset hold: rst=0 for 5 edges -> hs=0, vs=0, de=0, x=y=0, strobes 0, frame_cnt=0.
- Release: rst 0->1 -> first edge gives x=0, y=0, de=1, line_start=1, frame_start=1; next edge x=1, strobes 0.
- Line timing: count 24 cycles per line; de high cycles 0..15; hs high exactly cycles 18..21 of each line; line_start once per 24 cycles.
- Frame timing: vs high for exactly 48 consecutive cycles starting at y=13,x=0; de never high on lines 12..15; frame_start every 384 cycles; frame_cnt=1 after first wrap, 2 after second.
- Mid-frame reset: assert rst at y=5,x=7 -> outputs go to reset values without a clock edge; release -> restart at (0,0), frame_cnt=0.
- Polarity: HS_POL=0, VS_POL=0 -> hs/vs idle high and reset high, low during the same sync windows.
